ula_controller: RTL

Sequencer that fronts the calculator's 32-bit ULA. It accepts one arithmetic command at a time over a valid/ready handshake and validates the opcode and divisor. It drives the ULA operands and opcode for exactly the ULA's result latency, captures the registered ULA result, and holds it on a valid/ready response port. It also keeps a running accumulator, so chained calculator operations can use the previous result as the first operand.

---
 rtl/ula_pkg.sv | 37 +++
 rtl/ula_controller_if.sv | 50 +++++
 rtl/ula_controller.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// ----------------------------------------------------------------------------
// ula_pkg
// Shared definitions for the calculator's ULA front-end sequencer:
//   - one-hot ULA opcodes (OP_NOP makes the ULA hold its output)
//   - response error codes
//   - controller state encoding
//   - opcode legality helper
// ----------------------------------------------------------------------------
package ula_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_DIV = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_ADD = 4'b1000;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_DIV0    = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    // Only the four single-hot codes are real operations; anything else,
    // including the hold code, is rejected at command acceptance.
    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_DIV, OP_MUL, OP_SUB, OP_ADD: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ula_controller_if.sv
// ----------------------------------------------------------------------------
// ula_controller_if
// Bundles the sequencer's command, ULA drive, response and accumulator
// signals.
//   slave  : the controller side (accepts commands, drives the ULA)
//   master : the calculator side (issues commands, hosts the ULA)
// Command : _cmd_valid/_cmd_ready, _cmd_op1, _cmd_op2, _cmd_opcao, _cmd_use_acc
// Acc     : _acc_clear, _acc
// ULA     : _ula_op1, _ula_op2, _ula_opcao, _ula_result
// Response: _rsp_valid/_rsp_ready, _rsp_result, _rsp_err
// Status  : _busy
// ----------------------------------------------------------------------------
interface ula_controller_if;

    logic        _cmd_valid;
    logic        _cmd_ready;
    logic [31:0] _cmd_op1;
    logic [31:0] _cmd_op2;
    logic [3:0]  _cmd_opcao;
    logic        _cmd_use_acc;
    logic        _acc_clear;

    logic [31:0] _ula_op1;
    logic [31:0] _ula_op2;
    logic [3:0]  _ula_opcao;
    logic [31:0] _ula_result;

    logic        _rsp_valid;
    logic        _rsp_ready;
    logic [31:0] _rsp_result;
    logic [1:0]  _rsp_err;

    logic        _busy;
    logic [31:0] _acc;

    modport slave (
        input  _cmd_valid, _cmd_op1, _cmd_op2, _cmd_opcao, _cmd_use_acc,
        input  _acc_clear, _ula_result, _rsp_ready,
        output _cmd_ready, _ula_op1, _ula_op2, _ula_opcao,
        output _rsp_valid, _rsp_result, _rsp_err, _busy, _acc
    );

    modport master (
        output _cmd_valid, _cmd_op1, _cmd_op2, _cmd_opcao, _cmd_use_acc,
        output _acc_clear, _ula_result, _rsp_ready,
        input  _cmd_ready, _ula_op1, _ula_op2, _ula_opcao,
        input  _rsp_valid, _rsp_result, _rsp_err, _busy, _acc
    );

endinterface

// File: rtl/ula_controller.sv
// ----------------------------------------------------------------------------
// ula_controller
// Sequencer in front of the 32-bit ULA. Accepts one command at a time,
// rejects illegal opcodes and divide-by-zero without touching the ULA,
// otherwise drives the ULA for ULA_LAT cycles, captures its registered
// result and presents it on the response port. A running accumulator can
// replace op1 so calculator operations can be chained.
// Parameters: ULA_LAT  - ULA clock edges from stable inputs to valid result (>=1)
// Ports     : _clock   - rising-edge clock
//             _reset_n - asynchronous active-low reset
//             bus      - ula_controller_if.slave (command/ULA/response/acc)
// ----------------------------------------------------------------------------
module ula_controller #(
    parameter int ULA_LAT = 1
) (
    input  logic             _clock,
    input  logic             _reset_n,
    ula_controller_if.slave  bus
);

    import ula_pkg::*;

    localparam int               CNT_W    = (ULA_LAT > 1) ? $clog2(ULA_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ULA_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      ula_op1_r;
    logic [31:0]      ula_op2_r;
    logic [3:0]       ula_opcao_r;
    logic [31:0]      rsp_result_r;
    logic [1:0]       rsp_err_r;
    logic [31:0]      acc_r;

    logic        accept_s;
    logic        op_legal_s;
    logic        div0_s;
    logic        accept_ok_s;
    logic        accept_err_s;
    logic        issue_done_s;
    logic        capture_s;
    logic [31:0] eff_op1_s;
    logic        cmd_ready_s;
    logic        busy_s;
    logic        rsp_valid_s;

    // Command decode: a clear arriving with the command forces op1 to zero.
    always_comb begin
        accept_s     = (state_r == ST_IDLE) && bus._cmd_valid;
        op_legal_s   = is_legal_op(bus._cmd_opcao);
        div0_s       = (bus._cmd_opcao == OP_DIV) && (bus._cmd_op2 == 32'd0);
        accept_ok_s  = accept_s && op_legal_s && !div0_s;
        accept_err_s = accept_s && !accept_ok_s;
        issue_done_s = (state_r == ST_ISSUE) && (cnt_r == CNT_ZERO);
        capture_s    = (state_r == ST_CAPTURE);
        if (bus._cmd_use_acc) begin
            eff_op1_s = bus._acc_clear ? 32'd0 : acc_r;
        end else begin
            eff_op1_s = bus._cmd_op1;
        end
    end

    // State register.
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_err_s) begin
                    state_s = ST_RESP;
                end else if (accept_ok_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_CAPTURE;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_CAPTURE: begin
                state_s = ST_RESP;
            end
            ST_RESP: begin
                if (bus._rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the state register only.
    always_comb begin
        cmd_ready_s = 1'b0;
        busy_s      = 1'b1;
        rsp_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cmd_ready_s = 1'b1;
                busy_s      = 1'b0;
            end
            ST_ISSUE, ST_CAPTURE: begin
                busy_s = 1'b1;
            end
            ST_RESP: begin
                rsp_valid_s = 1'b1;
            end
            default: begin
                busy_s = 1'b1;
            end
        endcase
    end

    // Latency counter: preloaded while idle so it is ready at acceptance.
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            cnt_r <= CNT_ZERO;
        end else if (state_r == ST_IDLE) begin
            cnt_r <= CNT_LOAD;
        end else if ((state_r == ST_ISSUE) && (cnt_r != CNT_ZERO)) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end
    end

    // ULA drive: operands change only for commands that reach the ULA,
    // the opcode drops to hold as ISSUE ends so the result freezes.
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            ula_op1_r   <= 32'd0;
            ula_op2_r   <= 32'd0;
            ula_opcao_r <= OP_NOP;
        end else if (accept_ok_s) begin
            ula_op1_r   <= eff_op1_s;
            ula_op2_r   <= bus._cmd_op2;
            ula_opcao_r <= bus._cmd_opcao;
        end else if (issue_done_s) begin
            ula_opcao_r <= OP_NOP;
        end
    end

    // Response data: illegal opcode takes precedence over divide-by-zero.
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            rsp_result_r <= 32'd0;
            rsp_err_r    <= ERR_OK;
        end else if (accept_err_s) begin
            rsp_result_r <= 32'd0;
            rsp_err_r    <= op_legal_s ? ERR_DIV0 : ERR_ILLEGAL;
        end else if (capture_s) begin
            rsp_result_r <= bus._ula_result;
            rsp_err_r    <= ERR_OK;
        end
    end

    // Accumulator: clear beats a same-cycle capture.
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            acc_r <= 32'd0;
        end else if (bus._acc_clear) begin
            acc_r <= 32'd0;
        end else if (capture_s) begin
            acc_r <= bus._ula_result;
        end
    end

    assign bus._cmd_ready  = cmd_ready_s;
    assign bus._busy       = busy_s;
    assign bus._rsp_valid  = rsp_valid_s;
    assign bus._rsp_result = rsp_result_r;
    assign bus._rsp_err    = rsp_err_r;
    assign bus._acc        = acc_r;
    assign bus._ula_op1    = ula_op1_r;
    assign bus._ula_op2    = ula_op2_r;
    assign bus._ula_opcao  = ula_opcao_r;

endmodule
